// File: rtl/mem_responder.sv
// Purpose: memory-side responder for the processor bus: word RAM with byte lanes plus an LED/CNT/STAT page.
// Latency: read data is registered, valid one cycle after addr; writes are visible to the next cycle's read.
// Backpressure: none; a read is performed every cycle and a write is accepted on any cycle wr is high.
module mem_responder #(
  parameter int RAM_WORDS = 1024,
  parameter int LED_W     = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             wr,
  input  logic [3:0]       be,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] leds,
  output logic             fault
);

  localparam int AW = $clog2(RAM_WORDS);

  // Word addresses (byte address >> 2) of the peripheral page.
  localparam logic [29:0] LED_WA  = 30'h0400_0000;
  localparam logic [29:0] CNT_WA  = 30'h0400_0001;
  localparam logic [29:0] STAT_WA = 30'h0400_0002;

  // Where the registered read data comes from on the following cycle.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_REG  = 2'd2
  } rd_src_e;

  // Replace only the byte lanes selected by lane_en.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lane_en);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [29:0]   widx;
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          led_hit;
  logic          cnt_hit;
  logic          stat_hit;
  logic          mapped;
  logic          wr_act;
  logic          misalign;
  logic          wr_ok;
  logic          ram_we;

  assign widx     = addr[31:2];
  assign ram_idx  = widx[AW-1:0];
  assign ram_hit  = (widx[29:AW] == '0);
  assign led_hit  = (widx == LED_WA);
  assign cnt_hit  = (widx == CNT_WA);
  assign stat_hit = (widx == STAT_WA);
  assign mapped   = ram_hit | led_hit | cnt_hit | stat_hit;

  // An all-zero lane mask is a no-op and never counts as a fault.
  assign wr_act   = wr && (be != 4'b0000);
  assign misalign = wr_act && (addr[1:0] != 2'b00);
  // Unmapped writes need no explicit suppression: no hit signal is set for them.
  assign wr_ok    = wr_act && !misalign;
  assign ram_we   = wr_ok && ram_hit && !reset;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      mem [RAM_WORDS];
  logic [31:0]      ram_rd_q;

  logic [LED_W-1:0] leds_q, leds_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [1:0]       stat_q, stat_d;
  logic [1:0]       stat_clr;
  logic             fault_q;
  rd_src_e          rd_src_q, rd_src_d;
  logic [31:0]      reg_rd_q, reg_rd_d;

  // RAM array: read-first port, old word is captured while the same word is written.
  always_ff @(posedge clock) begin
    ram_rd_q <= mem[ram_idx];
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Next-state for peripheral registers; a new fault beats a clear on the same bit.
  always_comb begin
    leds_d   = leds_q;
    cnt_d    = cnt_q + 32'd1;
    stat_clr = 2'b00;
    if (wr_ok && led_hit) leds_d = LED_W'(merge_bytes(32'(leds_q), wdata, be));
    if (wr_ok && cnt_hit) cnt_d = merge_bytes(cnt_q, wdata, be);
    if (wr_ok && stat_hit && be[0]) stat_clr = wdata[1:0];
    // Every cycle is a read, so an unmapped address always records bit0.
    stat_d = (stat_q & ~stat_clr) | {misalign, !mapped};
  end

  // Read-side select and peripheral read value, captured with pre-write state.
  always_comb begin
    rd_src_d = SRC_ZERO;
    reg_rd_d = 32'd0;
    if (ram_hit) begin
      rd_src_d = SRC_RAM;
    end else if (led_hit) begin
      rd_src_d = SRC_REG;
      reg_rd_d = 32'(leds_q);
    end else if (cnt_hit) begin
      rd_src_d = SRC_REG;
      reg_rd_d = cnt_q;
    end else if (stat_hit) begin
      rd_src_d = SRC_REG;
      reg_rd_d = {30'd0, stat_q};
    end
  end

  // Register update; reset clears everything except the RAM array.
  always_ff @(posedge clock) begin
    if (reset) begin
      leds_q   <= '0;
      cnt_q    <= 32'd0;
      stat_q   <= 2'b00;
      fault_q  <= 1'b0;
      rd_src_q <= SRC_ZERO;
      reg_rd_q <= 32'd0;
    end else begin
      leds_q   <= leds_d;
      cnt_q    <= cnt_d;
      stat_q   <= stat_d;
      fault_q  <= |stat_d;
      rd_src_q <= rd_src_d;
      reg_rd_q <= reg_rd_d;
    end
  end

  // Output mux over registered sources only; reset forces the zero source.
  always_comb begin
    rdata = 32'd0;
    case (rd_src_q)
      SRC_RAM: rdata = ram_rd_q;
      SRC_REG: rdata = reg_rd_q;
      default: rdata = 32'd0;
    endcase
  end

  assign leds  = leds_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed vectors, behavioural memory-map model,
// per-cycle comparison of rdata/leds/fault plus literal spot checks.
module tb_mem_responder;

  localparam int RAM_WORDS = 1024;
  localparam int LED_W     = 10;

  localparam logic [31:0] A_LED  = 32'h1000_0000;
  localparam logic [31:0] A_CNT  = 32'h1000_0004;
  localparam logic [31:0] A_STAT = 32'h1000_0008;
  localparam logic [31:0] A_BAD  = 32'h2000_0000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      addr  = 32'd0;
  logic [31:0]      wdata = 32'd0;
  logic             wr    = 1'b0;
  logic [3:0]       be    = 4'd0;
  logic [31:0]      rdata;
  logic [LED_W-1:0] leds;
  logic             fault;

  always #5 clock = ~clock;

  mem_responder #(.RAM_WORDS(RAM_WORDS), .LED_W(LED_W)) dut (
    .clock (clock),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .wr    (wr),
    .be    (be),
    .rdata (rdata),
    .leds  (leds),
    .fault (fault)
  );

  // Model of the architectural state.
  logic [31:0]      m_ram   [RAM_WORDS];
  bit               m_known [RAM_WORDS];
  logic [31:0]      m_led;
  logic [31:0]      m_cnt;
  logic [1:0]       m_stat;

  // Expected outputs after the most recent edge.
  logic [31:0]      e_rdata;
  bit               e_rdata_chk;
  logic [LED_W-1:0] e_leds;
  logic             e_fault;
  bit               e_vld = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, got, want, $time);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // Apply one clock edge to the model using the inputs presented for it.
  task automatic model_edge(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [3:0] b);
    logic [31:0] rd;
    logic [31:0] mask;
    logic [31:0] nxt_cnt;
    logic [1:0]  setm;
    logic [1:0]  clrm;
    bit          rchk;
    bit          in_ram;
    int          idx;
    if (r) begin
      m_led       = 32'd0;
      m_cnt       = 32'd0;
      m_stat      = 2'b00;
      e_rdata     = 32'd0;
      e_rdata_chk = 1'b1;
    end else begin
      rd      = 32'd0;
      rchk    = 1'b1;
      setm    = 2'b00;
      clrm    = 2'b00;
      mask    = lane_mask(b);
      in_ram  = (a < RAM_WORDS * 4);
      idx     = in_ram ? int'(a >> 2) : 0;
      nxt_cnt = m_cnt + 32'd1;
      // Read side uses state from before this edge.
      if (in_ram) begin
        rd   = m_ram[idx];
        rchk = m_known[idx];
      end else if ((a & ~32'd3) == A_LED)  rd = m_led;
      else if ((a & ~32'd3) == A_CNT)      rd = m_cnt;
      else if ((a & ~32'd3) == A_STAT)     rd = {30'd0, m_stat};
      else                                 setm[0] = 1'b1;
      // Write side.
      if (w && b != 4'b0000) begin
        if (a[1:0] != 2'b00) begin
          setm[1] = 1'b1;
        end else if (in_ram) begin
          if (!m_known[idx] && b != 4'b1111) begin
            m_known[idx] = 1'b0;
          end else begin
            m_ram[idx]   = (m_ram[idx] & ~mask) | (d & mask);
            m_known[idx] = 1'b1;
          end
        end else if (a == A_LED) begin
          m_led = ((m_led & ~mask) | (d & mask)) & 32'((64'd1 << LED_W) - 64'd1);
        end else if (a == A_CNT) begin
          nxt_cnt = (m_cnt & ~mask) | (d & mask);
        end else if (a == A_STAT) begin
          if (b[0]) clrm = d[1:0];
        end
      end
      m_stat      = (m_stat & ~clrm) | setm;
      m_cnt       = nxt_cnt;
      e_rdata     = rd;
      e_rdata_chk = rchk;
    end
    e_leds  = m_led[LED_W-1:0];
    e_fault = |m_stat;
  endtask

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [3:0] b);
    reset = r;
    addr  = a;
    wdata = d;
    wr    = w;
    be    = b;
    @(posedge clock);
    #1;
    model_edge(r, a, d, w, b);
    e_vld = 1'b1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (e_vld) begin
      if (e_rdata_chk) chk("rdata", rdata, e_rdata);
      chk("leds", 32'(leds), 32'(e_leds));
      chk("fault", {31'd0, fault}, {31'd0, e_fault});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
    m_led  = 32'd0;
    m_cnt  = 32'd0;
    m_stat = 2'b00;

    // Reset with an LED write presented: the write must be suppressed.
    step(1, A_LED, 32'h0000_00FF, 1, 4'b1111);
    step(1, A_LED, 32'h0000_00FF, 1, 4'b1111);
    chk("lit_reset_rdata", rdata, 32'h0);
    chk("lit_reset_leds", 32'(leds), 32'h0);
    chk("lit_reset_fault", {31'd0, fault}, 32'h0);

    // Full-word write then read.
    step(0, 32'h0000_0010, 32'hDEAD_BEEF, 1, 4'b1111);
    step(0, 32'h0000_0010, 32'h0, 0, 4'b0000);
    chk("lit_word_rd", rdata, 32'hDEAD_BEEF);

    // Byte-lane write.
    step(0, 32'h0000_0020, 32'h1122_3344, 1, 4'b1111);
    step(0, 32'h0000_0020, 32'hAABB_CCDD, 1, 4'b0101);
    step(0, 32'h0000_0020, 32'h0, 0, 4'b0000);
    chk("lit_lane_rd", rdata, 32'h11BB_33DD);

    // Read-first on the same word.
    step(0, 32'h0000_0030, 32'h1, 1, 4'b1111);
    step(0, 32'h0000_0030, 32'h2, 1, 4'b1111);
    chk("lit_rdfirst_old", rdata, 32'h1);
    step(0, 32'h0000_0030, 32'h0, 0, 4'b0000);
    chk("lit_rdfirst_new", rdata, 32'h2);

    // Counter load, wrap, then reset.
    step(0, A_CNT, 32'hFFFF_FFFE, 1, 4'b1111);
    step(0, A_CNT, 32'h0, 0, 4'b0000);
    chk("lit_cnt_0", rdata, 32'hFFFF_FFFE);
    step(0, A_CNT, 32'h0, 0, 4'b0000);
    chk("lit_cnt_1", rdata, 32'hFFFF_FFFF);
    step(0, A_CNT, 32'h0, 0, 4'b0000);
    chk("lit_cnt_wrap", rdata, 32'h0);
    step(1, A_CNT, 32'h0, 0, 4'b0000);
    step(0, A_CNT, 32'h0, 0, 4'b0000);
    chk("lit_cnt_after_reset", rdata, 32'h0);

    // LED register.
    step(0, A_LED, 32'hFFFF_FFFF, 1, 4'b1111);
    chk("lit_leds_set", 32'(leds), 32'h3FF);
    step(0, A_LED, 32'h0, 0, 4'b0000);
    chk("lit_leds_rd", rdata, 32'h0000_03FF);

    // Faults.
    step(0, 32'h0000_0000, 32'hCAFE_F00D, 1, 4'b1111);
    step(0, A_BAD, 32'h0, 0, 4'b0000);
    chk("lit_unmapped_rd", rdata, 32'h0);
    chk("lit_unmapped_fault", {31'd0, fault}, 32'h1);
    step(0, A_STAT, 32'h0, 0, 4'b0000);
    chk("lit_stat_1", rdata, 32'h1);
    step(0, 32'h0000_0002, 32'h1234_5678, 1, 4'b1111);
    step(0, 32'h0000_0000, 32'h0, 0, 4'b0000);
    chk("lit_misalign_ram", rdata, 32'hCAFE_F00D);
    step(0, A_STAT, 32'h0, 0, 4'b0000);
    chk("lit_stat_3", rdata, 32'h3);
    step(0, A_STAT, 32'h1, 1, 4'b1111);
    step(0, A_BAD, 32'h0, 0, 4'b0000);
    step(0, A_STAT, 32'h0, 0, 4'b0000);
    chk("lit_stat_bit0_again", rdata, 32'h3);
    step(0, A_STAT, 32'h3, 1, 4'b1111);
    chk("lit_fault_clear", {31'd0, fault}, 32'h0);
    step(0, 32'h0000_0003, 32'hFFFF_FFFF, 1, 4'b0000);
    step(0, A_STAT, 32'h0, 0, 4'b0000);
    chk("lit_be0_nofault", rdata, 32'h0);
    step(0, 32'h0000_0000, 32'h0, 0, 4'b0000);
    chk("lit_be0_noop", rdata, 32'hCAFE_F00D);

    // LED cleared by reset.
    step(1, A_LED, 32'h0, 0, 4'b0000);
    chk("lit_leds_reset", 32'(leds), 32'h0);
    step(0, A_LED, 32'h0, 0, 4'b0000);
    chk("lit_leds_rd_reset", rdata, 32'h0);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
